product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 102 ++++++++++
 tb/tb_product_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates a run of sign-magnitude products into a two's-complement sum.
// A start in IDLE opens a run of len terms; the result is held until out_ready.
module product_accumulator #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [63:0]      product,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_result,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a product transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. Neither
  // valid may depend on its own ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             ovf, ovf_nxt;

  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             handshake;

  // Negative zero negates to zero, so it adds nothing and cannot overflow.
  always_comb begin
    mag_ext = {{(ACC_W-63){1'b0}}, product[62:0]};
    term    = product[63] ? -mag_ext : mag_ext;
    sum     = acc + term;
    add_ovf = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign busy       = (state != IDLE);
  assign handshake  = in_valid && in_ready;
  assign acc_result = acc;
  assign overflow   = ovf;
  assign state_dbg  = state;

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          remaining_nxt = len;
          state_nxt     = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (handshake) begin
          acc_nxt       = sum;
          ovf_nxt       = ovf | add_ovf;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed vectors with hand-computed results,
// then a randomized run scored against a small reference model.
module tb_product_accumulator;

  localparam int ACC_W = 66;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [63:0]      product = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_result;
  logic             overflow;
  logic             busy;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  logic [ACC_W:0]   exp_q[$];
  logic [ACC_W-1:0] exp_acc;
  logic             exp_ovf;

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .acc_result(acc_result), .overflow(overflow),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Result monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got ovf=%b acc=%h, required no result", overflow, acc_result);
      end else begin
        logic [ACC_W:0] e;
        e = exp_q.pop_front();
        if ({overflow, acc_result} !== e) begin
          n_fail++;
          $display("FAIL result: got ovf=%b acc=%h, required ovf=%b acc=%h",
                   overflow, acc_result, e[ACC_W], e[ACC_W-1:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_add(input logic [63:0] p);
    logic [ACC_W-1:0] mag, t, s;
    mag = ACC_W'(p[62:0]);
    t = p[63] ? (~mag + 1'b1) : mag;
    s = exp_acc + t;
    if ((exp_acc[ACC_W-1] == t[ACC_W-1]) && (s[ACC_W-1] != exp_acc[ACC_W-1])) exp_ovf = 1'b1;
    exp_acc = s;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int n);
    start = 1'b1;
    len = CNT_W'(n);
    tick();
    start = 1'b0;
    len = CNT_W'($urandom);
    exp_acc = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic send(input logic [63:0] p, input int gaps);
    int t;
    in_valid = 1'b0;
    repeat (gaps) tick();
    product = p;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    product = {$urandom, $urandom};
    model_add(p);
  endtask

  task automatic finish_out(input int hold_cycles);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    check("out_valid_wait", out_valid, 1);
    repeat (hold_cycles) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("busy_after_out", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_acc = '0;
    exp_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", acc_result, 0);
    check("rst_overflow", overflow, 0);

    // Basic sum: 5 - 2 + 10 = 13
    start_op(3);
    send(64'h0000_0000_0000_0005, 0);
    send(64'h8000_0000_0000_0002, 0);
    send(64'h0000_0000_0000_000A, 0);
    check("basic_out_valid", out_valid, 1);
    check("basic_acc", acc_result, 13);
    check("basic_overflow", overflow, 0);
    exp_q.push_back({1'b0, 66'd13});
    finish_out(0);
    check("idle_acc_readable", acc_result, 13);

    // Zero length
    start_op(0);
    check("zero_len_out_valid", out_valid, 1);
    check("zero_len_acc", acc_result, 0);
    exp_q.push_back({1'b0, 66'd0});
    finish_out(0);

    // Negative zero then -7
    start_op(2);
    send(64'h8000_0000_0000_0000, 0);
    check("negzero_acc", acc_result, 0);
    check("negzero_overflow", overflow, 0);
    send(64'h8000_0000_0000_0007, 0);
    check("neg7_acc", acc_result, 66'h3_FFFF_FFFF_FFFF_FFF9);
    exp_q.push_back({1'b0, 66'h3_FFFF_FFFF_FFFF_FFF9});
    finish_out(0);

    // Backpressure on input, then a stalled HOLD with ignored starts
    start_op(4);
    send(64'd1, 0);
    check("bp_acc1", acc_result, 1);
    in_valid = 1'b0;
    tick();
    check("bp_gap_acc", acc_result, 1);
    send(64'd2, 1);
    check("bp_acc2", acc_result, 3);
    send(64'd3, 1);
    check("bp_acc3", acc_result, 6);
    send(64'd4, 1);
    check("bp_acc4", acc_result, 10);
    exp_q.push_back({1'b0, 66'd10});
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len = CNT_W'(3);
      tick();
      start = 1'b0;
      check("hold_acc", acc_result, 10);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    finish_out(0);
    check("bp_idle_out_valid", out_valid, 0);

    // Overflow: 5 * (2^63 - 1) in 66 bits
    start_op(5);
    for (int i = 0; i < 5; i++) begin
      send(64'h7FFF_FFFF_FFFF_FFFF, 0);
      if (i == 3) check("ovf_after4", overflow, 0);
    end
    check("ovf_after5", overflow, 1);
    check("ovf_acc", acc_result, 66'h2_7FFF_FFFF_FFFF_FFFB);
    exp_q.push_back({1'b1, 66'h2_7FFF_FFFF_FFFF_FFFB});
    repeat (3) tick();
    check("ovf_hold_sticky", overflow, 1);
    finish_out(0);

    // Reset mid-accumulation
    start_op(4);
    send(64'd100, 0);
    send(64'd200, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_acc", acc_result, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_overflow", overflow, 0);
    start_op(1);
    send(64'd9, 0);
    check("post_rst_acc", acc_result, 9);
    exp_q.push_back({1'b0, 66'd9});
    finish_out(0);

    // Randomized accumulations against the model
    for (int k = 0; k < 300; k++) begin
      int n;
      n = ($urandom_range(0, 49) == 0) ? 255 : $urandom_range(0, 20);
      start_op(n);
      for (int j = 0; j < n; j++) begin
        logic [63:0] p;
        p = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: p[62:0] = '1;
          1: p[62:0] = '0;
          default: ;
        endcase
        send(p, $urandom_range(0, 2));
      end
      exp_q.push_back({exp_ovf, exp_acc});
      finish_out($urandom_range(0, 3));
    end

    repeat (3) tick();
    check("queue_drained", 128'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
